dac_cmd_sequencer: RTL and testbench

//  Queues DAC write commands from the CUPPA register block and issues them one at a time
//  to the DAC SPI master using its req/ack handshake.

---
 rtl/dac_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_dac_cmd_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_cmd_sequencer.sv
// rtl/dac_cmd_sequencer.sv - queued DAC write command sequencer for the 24-bit DAC SPI master
//
// Accepts {sel, data} commands into a small FIFO. It issues them one at a time to
// spi_master using the wr_req/ack handshake. After each transfer it forces a CSn-high
// gap. If no ack arrives, it aborts the transfer on a timeout.
//
// Ports:
//   clk, rst                 lclk, synchronous active-high reset
//   cmd_valid/cmd_ready      command push handshake; cmd_sel, cmd_data carry the command
//   spi_wr_req/spi_wr_data   request and word to spi_master; spi_sel selects the DAC
//   spi_ack                  transfer-complete strobe from spi_master
//   flush                    discard every queued command that is not yet in flight
//   err_clr                  clear the sticky err_timeout flag
//   busy, fifo_count         activity and queue occupancy status
//   err_timeout              sticky flag: a transfer was aborted without ack
module dac_cmd_sequencer #(
   parameter int P_DEPTH   = 8,
   parameter int P_GAP     = 16,
   parameter int P_TIMEOUT = 4096
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic                           cmd_sel,
   input  logic [23:0]                    cmd_data,
   output logic                           spi_wr_req,
   output logic [23:0]                    spi_wr_data,
   output logic                           spi_sel,
   input  logic                           spi_ack,
   input  logic                           flush,
   input  logic                           err_clr,
   output logic                           busy,
   output logic [$clog2(P_DEPTH+1)-1:0]   fifo_count,
   output logic                           err_timeout
);

   localparam int AW = $clog2(P_DEPTH);
   localparam int CW = $clog2(P_DEPTH + 1);
   localparam int TW = $clog2(P_TIMEOUT);
   localparam int GW = $clog2(P_GAP + 1);
   localparam logic [TW-1:0] T_LAST = TW'(P_TIMEOUT - 1);
   localparam logic [GW-1:0] G_LAST = GW'(P_GAP - 1);

   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

   state_t          state, state_next;
   logic [24:0]     mem [P_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [TW-1:0]   timer;
   logic [GW-1:0]   gap_cnt;
   logic            push, pop, err_set;

   // The ready signal uses the registered count only, so a same-cycle pop never frees a slot.
   assign cmd_ready = (fifo_count < CW'(P_DEPTH)) && !flush;
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE) || (fifo_count != '0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_count != '0 && !flush) begin
               pop        = 1'b1;
               state_next = XFER;
            end
         end
         XFER: begin
            // Ack takes priority over a timeout that expires in the same cycle.
            if (spi_ack) begin
               state_next = GAP;
            end else if (timer == T_LAST) begin
               err_set    = 1'b1;
               state_next = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == G_LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Storage has no reset; occupancy is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_sel, cmd_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         spi_wr_req  <= 1'b0;
         spi_wr_data <= '0;
         spi_sel     <= 1'b0;
         err_timeout <= 1'b0;
         timer       <= '0;
         gap_cnt     <= '0;
      end else begin
         if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);
         end

         // Data and select only change on a pop, so they hold while req is low.
         if (pop) begin
            spi_wr_req               <= 1'b1;
            {spi_sel, spi_wr_data}   <= mem[rd_ptr];
         end else if (state == XFER && state_next == GAP) begin
            spi_wr_req <= 1'b0;
         end

         timer   <= (state == XFER) ? timer + TW'(1) : '0;
         gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;

         if (err_set)      err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dac_cmd_sequencer.sv
// tb/tb_dac_cmd_sequencer.sv - directed self-checking bench for dac_cmd_sequencer
module tb_dac_cmd_sequencer;

   localparam int P_DEPTH   = 8;
   localparam int P_GAP     = 16;
   localparam int P_TIMEOUT = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_sel = 1'b0;
   logic [23:0] cmd_data = '0;
   logic        spi_wr_req;
   logic [23:0] spi_wr_data;
   logic        spi_sel;
   logic        spi_ack = 1'b0;
   logic        flush = 1'b0;
   logic        err_clr = 1'b0;
   logic        busy;
   logic [3:0]  fifo_count;
   logic        err_timeout;

   int total = 0;
   int bad   = 0;

   dac_cmd_sequencer #(.P_DEPTH(P_DEPTH), .P_GAP(P_GAP), .P_TIMEOUT(P_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_data(cmd_data), .spi_wr_req(spi_wr_req),
      .spi_wr_data(spi_wr_data), .spi_sel(spi_sel), .spi_ack(spi_ack),
      .flush(flush), .err_clr(err_clr), .busy(busy), .fifo_count(fifo_count),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic s, input logic [23:0] d);
      cmd_valid = 1'b1;
      cmd_sel   = s;
      cmd_data  = d;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_req(input logic lvl, input int budget, output int n);
      n = 0;
      while (spi_wr_req !== lvl && n < budget) begin
         step();
         n++;
      end
      if (spi_wr_req !== lvl) n = -1;
   endtask

   task automatic do_ack(input int delay);
      for (int i = 0; i < delay; i++) step();
      spi_ack = 1'b1;
      step();
      spi_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (spi_wr_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", spi_wr_req); end
      total++; if (spi_wr_data !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", spi_wr_data); end
      total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
      total++; if (busy !== 1'b0 || err_timeout !== 1'b0 || spi_sel !== 1'b0) begin bad++;
         $display("FAIL reset_flags got busy=%0b err=%0b sel=%0b exp=000", busy, err_timeout, spi_sel); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int n;
      push_cmd(1'b0, 24'h308000);
      total++; if (spi_wr_req !== 1'b0 || fifo_count !== 4'd1 || busy !== 1'b1) begin bad++;
         $display("FAIL single_after_push got req=%0b cnt=%0d busy=%0b exp req=0 cnt=1 busy=1", spi_wr_req, fifo_count, busy); end
      wait_req(1'b1, 10, n);
      total++; if (n !== 1) begin bad++; $display("FAIL single_latency got=%0d exp=1", n); end
      total++; if (spi_wr_data !== 24'h308000 || spi_sel !== 1'b0) begin bad++;
         $display("FAIL single_data got=%h/%0b exp=308000/0", spi_wr_data, spi_sel); end
      total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", fifo_count); end
      do_ack(24);
      total++; if (spi_wr_req !== 1'b0) begin bad++; $display("FAIL single_req_fall got=%0b exp=0", spi_wr_req); end
      n = 0;
      while (busy === 1'b1 && n < 100) begin step(); n++; end
      // req fell one cycle after ack; busy must fall P_GAP+1 cycles after the ack cycle
      total++; if (n + 1 !== P_GAP + 1) begin bad++; $display("FAIL single_busy_fall got=%0d exp=%0d", n + 1, P_GAP + 1); end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [23:0] dat [3];
      logic        sl [3];
      dat[0] = 24'h3A1234; dat[1] = 24'h3B5678; dat[2] = 24'h3C9ABC;
      sl[0] = 1'b0; sl[1] = 1'b1; sl[2] = 1'b0;
      push_cmd(1'b1, 24'h111111);
      wait_req(1'b1, 10, n);
      do_ack(3);
      for (int i = 0; i < 3; i++) push_cmd(sl[i], dat[i]);
      total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL b2b_count3 got=%0d exp=3", fifo_count); end
      wait_req(1'b1, 100, n);
      total++; if (n !== P_GAP + 1 - 3) begin bad++; $display("FAIL b2b_first_gap got=%0d exp=%0d", n, P_GAP - 2); end
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            wait_req(1'b1, 100, n);
            total++; if (n !== P_GAP + 1) begin bad++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, n, P_GAP + 1); end
         end
         total++; if (spi_wr_data !== dat[i] || spi_sel !== sl[i]) begin bad++;
            $display("FAIL b2b_word%0d got=%h/%0b exp=%h/%0b", i, spi_wr_data, spi_sel, dat[i], sl[i]); end
         total++; if (fifo_count !== 4'(2 - i)) begin bad++; $display("FAIL b2b_cnt%0d got=%0d exp=%0d", i, fifo_count, 2 - i); end
         do_ack(2);
         total++; if (spi_wr_req !== 1'b0) begin bad++; $display("FAIL b2b_fall%0d got=%0b exp=0", i, spi_wr_req); end
      end
   endtask

   task automatic test_full();
      int n;
      push_cmd(1'b0, 24'hA00000);
      wait_req(1'b1, 100, n);
      for (int i = 1; i <= P_DEPTH; i++) push_cmd(i[0], 24'hA00000 + 24'(i));
      total++; if (fifo_count !== 4'(P_DEPTH) || cmd_ready !== 1'b0) begin bad++;
         $display("FAIL full_state got cnt=%0d ready=%0b exp cnt=%0d ready=0", fifo_count, cmd_ready, P_DEPTH); end
      push_cmd(1'b1, 24'hBADBAD);
      total++; if (fifo_count !== 4'(P_DEPTH)) begin bad++; $display("FAIL full_drop got=%0d exp=%0d", fifo_count, P_DEPTH); end
      for (int i = 0; i <= P_DEPTH; i++) begin
         if (i > 0) wait_req(1'b1, 100, n);
         total++; if (spi_wr_req !== 1'b1 || spi_wr_data !== 24'hA00000 + 24'(i) || spi_sel !== i[0]) begin bad++;
            $display("FAIL full_word%0d got req=%0b %h/%0b exp req=1 %h/%0b", i, spi_wr_req, spi_wr_data, spi_sel, 24'hA00000 + 24'(i), i[0]); end
         do_ack(1);
      end
      n = 0;
      while (busy === 1'b1 && n < 100) begin step(); n++; end
      total++; if (busy !== 1'b0 || fifo_count !== 4'd0) begin bad++;
         $display("FAIL full_drained got busy=%0b cnt=%0d exp busy=0 cnt=0", busy, fifo_count); end
   endtask

   task automatic test_timeout();
      int n;
      push_cmd(1'b1, 24'h123456);
      wait_req(1'b1, 10, n);
      wait_req(1'b0, P_TIMEOUT + 50, n);
      total++; if (n !== P_TIMEOUT) begin bad++; $display("FAIL to_len got=%0d exp=%0d", n, P_TIMEOUT); end
      total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err got=%0b exp=1", err_timeout); end
      push_cmd(1'b0, 24'h654321);
      wait_req(1'b1, 100, n);
      total++; if (n < 0 || spi_wr_data !== 24'h654321) begin bad++; $display("FAIL to_next got=%h exp=654321", spi_wr_data); end
      do_ack(1);
      total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0b exp=1", err_timeout); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_clr got=%0b exp=0", err_timeout); end
      n = 0;
      while (busy === 1'b1 && n < 100) begin step(); n++; end
      push_cmd(1'b0, 24'h777777);
      wait_req(1'b1, 10, n);
      for (int i = 0; i < P_TIMEOUT - 1; i++) step();
      spi_ack = 1'b1;
      step();
      spi_ack = 1'b0;
      total++; if (spi_wr_req !== 1'b0 || err_timeout !== 1'b0) begin bad++;
         $display("FAIL to_ack_wins got req=%0b err=%0b exp req=0 err=0", spi_wr_req, err_timeout); end
      n = 0;
      while (busy === 1'b1 && n < 100) begin step(); n++; end
   endtask

   task automatic test_flush();
      int n;
      int seen;
      push_cmd(1'b0, 24'hF00000);
      wait_req(1'b1, 10, n);
      for (int i = 1; i <= 4; i++) push_cmd(1'b1, 24'hF00000 + 24'(i));
      total++; if (fifo_count !== 4'd4) begin bad++; $display("FAIL fl_count got=%0d exp=4", fifo_count); end
      flush     = 1'b1;
      cmd_valid = 1'b1;
      cmd_data  = 24'hEEEEEE;
      #1;
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%0b exp=0", cmd_ready); end
      step();
      flush     = 1'b0;
      cmd_valid = 1'b0;
      total++; if (fifo_count !== 4'd0 || spi_wr_req !== 1'b1 || spi_wr_data !== 24'hF00000) begin bad++;
         $display("FAIL fl_after got cnt=%0d req=%0b data=%h exp cnt=0 req=1 data=f00000", fifo_count, spi_wr_req, spi_wr_data); end
      do_ack(2);
      seen = 0;
      for (int i = 0; i < P_GAP + 10; i++) begin
         if (spi_wr_req === 1'b1) seen++;
         step();
      end
      total++; if (seen !== 0 || busy !== 1'b0) begin bad++; $display("FAIL fl_no_req got seen=%0d busy=%0b exp 0/0", seen, busy); end
   endtask

   task automatic test_rst_mid();
      int n;
      push_cmd(1'b1, 24'hC0FFEE);
      wait_req(1'b1, 10, n);
      push_cmd(1'b1, 24'hC00001);
      push_cmd(1'b0, 24'hC00002);
      rst = 1'b1;
      step();
      total++; if (spi_wr_req !== 1'b0 || spi_wr_data !== 24'h0 || spi_sel !== 1'b0) begin bad++;
         $display("FAIL rst_spi got req=%0b data=%h sel=%0b exp 0/0/0", spi_wr_req, spi_wr_data, spi_sel); end
      total++; if (fifo_count !== 4'd0 || busy !== 1'b0 || err_timeout !== 1'b0) begin bad++;
         $display("FAIL rst_status got cnt=%0d busy=%0b err=%0b exp 0/0/0", fifo_count, busy, err_timeout); end
      rst = 1'b0;
      push_cmd(1'b1, 24'h0ABCDE);
      wait_req(1'b1, 10, n);
      total++; if (n !== 1 || spi_wr_data !== 24'h0ABCDE || spi_sel !== 1'b1) begin bad++;
         $display("FAIL rst_after got n=%0d data=%h sel=%0b exp 1/0abcde/1", n, spi_wr_data, spi_sel); end
      do_ack(1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_timeout();
      test_flush();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
